// File: rtl/ssd_pkg.sv
// ssd_pkg: shared definitions for the seven-segment TDM display scheduler.
//   state_e      - scheduler FSM states (idle / dead-time blank / digit lit)
//   SEG_OFF      - active-low "all segments dark" pattern
//   GLYPH_x      - active-low a..g patterns for hex digits 0-F, seg[0]=a
package ssd_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

endpackage

// File: rtl/ssd_hex_decoder.sv
// ssd_hex_decoder: combinational hex nibble to active-low seven-segment glyph.
//   nib - hex value 0..F
//   seg - segments a..g, active-low, seg[0]=a
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nib)
      4'h0: seg = GLYPH_0;
      4'h1: seg = GLYPH_1;
      4'h2: seg = GLYPH_2;
      4'h3: seg = GLYPH_3;
      4'h4: seg = GLYPH_4;
      4'h5: seg = GLYPH_5;
      4'h6: seg = GLYPH_6;
      4'h7: seg = GLYPH_7;
      4'h8: seg = GLYPH_8;
      4'h9: seg = GLYPH_9;
      4'hA: seg = GLYPH_A;
      4'hB: seg = GLYPH_B;
      4'hC: seg = GLYPH_C;
      4'hD: seg = GLYPH_D;
      4'hE: seg = GLYPH_E;
      4'hF: seg = GLYPH_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/ssd_tdm_scheduler.sv
// ssd_tdm_scheduler: time-division multiplexes N_DIGITS hex digits onto a shared
// active-low seven-segment bus. Each slot is BLANK_CYCLES dark cycles followed by
// the digit lit for the rest of the slot; digit 0 (rightmost) leads every frame.
// New digit values are only taken at frame boundaries so a frame is never mixed.
//   clk, rst     - system clock, synchronous active-high reset
//   en           - run enable; low forces the display dark and the FSM idle
//   digits_in    - 4*N_DIGITS hex nibbles, digit 0 in bits [3:0]
//   load         - level request to latch digits_in at the next frame boundary
//   lz_blank     - blank leading zero digits (digit 0 is never blanked)
//   load_ack     - pulse: digits_in latched at this boundary
//   frame_start  - pulse at each frame boundary
//   an           - anode enables, active-low
//   seg          - segments a..g, active-low, seg[0]=a
//
// Handshake: load is a level; it is honoured only on a cycle whose edge is a frame
// boundary, and load_ack pulses in the same cycle as frame_start. A load that
// drops before a boundary is simply never seen. All outputs are registered.
module ssd_tdm_scheduler
  import ssd_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int FRAME_HZ     = 1000,
  parameter int N_DIGITS     = 4,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic                  load,
  input  logic                  lz_blank,
  output logic                  load_ack,
  output logic                  frame_start,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg
);

  localparam int SLOT_CYCLES = CLK_HZ / (FRAME_HZ * N_DIGITS);
  localparam int CNT_W       = $clog2(SLOT_CYCLES);
  localparam int IDX_W       = $clog2(N_DIGITS);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*N_DIGITS-1:0] shadow_q;
  logic                  boundary;

  logic [3:0]            cur_nib;
  logic [6:0]            dec_seg;
  logic [6:0]            lit_seg;
  logic [N_DIGITS-1:0]   lz_mask;
  logic [N_DIGITS-1:0]   an_onehot;
  logic                  upper_zero;

  // Slot/frame sequencing. en low wins over everything, including a boundary.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    boundary = 1'b0;
    if (!en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d  = S_BLANK;
          cnt_d    = '0;
          idx_d    = '0;
          boundary = 1'b1;
        end
        S_BLANK: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == BLANK_LAST) state_d = S_SHOW;
        end
        S_SHOW: begin
          if (cnt_q == SLOT_LAST) begin
            state_d = S_BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d    = '0;
              boundary = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // lz_mask[i] is set when shadow digits N_DIGITS-1..i are all zero.
  always_comb begin
    upper_zero = 1'b1;
    lz_mask    = '0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero & (shadow_q[4*i +: 4] == 4'h0);
      lz_mask[i] = upper_zero;
    end
  end

  // Whenever the next state is SHOW, idx and shadow are unchanged by this edge,
  // so the current registers already select the digit about to be lit.
  assign cur_nib = shadow_q[{idx_q, 2'b00} +: 4];

  ssd_hex_decoder u_dec (
    .nib (cur_nib),
    .seg (dec_seg)
  );

  assign lit_seg = (lz_blank && lz_mask[idx_q]) ? SEG_OFF : dec_seg;

  always_comb begin
    an_onehot        = '0;
    an_onehot[idx_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shadow_q    <= '0;
      frame_start <= 1'b0;
      load_ack    <= 1'b0;
      an          <= '1;
      seg         <= SEG_OFF;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      frame_start <= boundary;
      load_ack    <= boundary & load;
      if (boundary && load) shadow_q <= digits_in;
      if (state_d == S_SHOW) begin
        an  <= ~an_onehot;
        seg <= lit_seg;
      end else begin
        an  <= '1;
        seg <= SEG_OFF;
      end
    end
  end

endmodule

// File: tb/tb_ssd_tdm_scheduler.sv
// tb_ssd_tdm_scheduler: directed bench for ssd_tdm_scheduler with
// CLK_HZ=1000, FRAME_HZ=25, N_DIGITS=4, BLANK_CYCLES=2 (10-cycle slots,
// 40-cycle frames). The stimulus side drives inputs and pushes the expected
// registered outputs; a negedge monitor pops and compares, and also watches
// for two lit anodes or an anode change without two dark cycles between.
module tb_ssd_tdm_scheduler;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] digits_in;
  logic        load;
  logic        lz_blank;
  logic        load_ack;
  logic        frame_start;
  logic [3:0]  an;
  logic [6:0]  seg;

  // Active-low glyphs 0..F, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] GLYPH_TB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  ssd_tdm_scheduler #(
    .CLK_HZ       (1000),
    .FRAME_HZ     (25),
    .N_DIGITS     (4),
    .BLANK_CYCLES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .digits_in   (digits_in),
    .load        (load),
    .lz_blank    (lz_blank),
    .load_ack    (load_ack),
    .frame_start (frame_start),
    .an          (an),
    .seg         (seg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [12:0] exp_q[$];   // {frame_start, load_ack, an, seg}
  int          tag_q[$];
  int          vectors    = 0;
  int          miscompares = 0;
  int          cur_tag    = 0;
  int          cycle_no   = 0;

  // Positional reference: m_t is the cycle index within the running frame.
  logic        m_run    = 1'b0;
  int          m_t      = 0;
  logic [15:0] m_shadow = 16'h0000;

  // ---------------- driver tasks ----------------
  task automatic step(input logic r, input logic e, input logic l,
                      input logic lz, input logic [15:0] d);
    logic       fs;
    logic       ack;
    logic [3:0] a;
    logic [6:0] s;
    logic [3:0] nib;
    int         slot;
    int         pos;
    rst       = r;
    en        = e;
    load      = l;
    lz_blank  = lz;
    digits_in = d;
    fs  = 1'b0;
    ack = 1'b0;
    a   = 4'hF;
    s   = 7'h7F;
    if (r) begin
      m_run    = 1'b0;
      m_t      = 0;
      m_shadow = 16'h0000;
    end else if (!e) begin
      m_run = 1'b0;
    end else begin
      if (!m_run) begin
        m_run = 1'b1;
        m_t   = 0;
      end else begin
        m_t = (m_t + 1) % 40;
      end
      if (m_t == 0) begin
        fs = 1'b1;
        if (l) begin
          ack      = 1'b1;
          m_shadow = d;
        end
      end
      slot = m_t / 10;
      pos  = m_t % 10;
      if (pos >= 2) begin
        a[slot] = 1'b0;
        nib = m_shadow[4*slot +: 4];
        if (lz && slot >= 1 && (m_shadow >> (4*slot)) == 16'h0000) s = 7'h7F;
        else s = GLYPH_TB[nib];
      end
    end
    @(posedge clk);
    #1;
    exp_q.push_back({fs, ack, a, s});
    tag_q.push_back(cur_tag);
  endtask

  task automatic run(input int n, input logic e, input logic l,
                     input logic lz, input logic [15:0] d);
    for (int i = 0; i < n; i++) step(1'b0, e, l, lz, d);
  endtask

  // Steps until the reference frame position reaches target (bounded).
  task automatic advance_to(input int target, input logic l,
                            input logic lz, input logic [15:0] d);
    int guard;
    guard = 0;
    while (m_t != target && guard < 100) begin
      step(1'b0, 1'b1, l, lz, d);
      guard++;
    end
  endtask

  // ---------------- monitor ----------------
  logic [3:0] prev_an  = 4'hF;
  int         dark_run = 0;

  always @(negedge clk) begin
    logic [12:0] e;
    logic [12:0] got;
    int          t;
    cycle_no++;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      t   = tag_q.pop_front();
      got = {frame_start, load_ack, an, seg};
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL outputs tag=%0d cycle=%0d got fs=%b ack=%b an=%b seg=%h expected fs=%b ack=%b an=%b seg=%h",
                 t, cycle_no, got[12], got[11], got[10:7], got[6:0],
                 e[12], e[11], e[10:7], e[6:0]);
      end
    end
    if (!$isunknown(an)) begin
      vectors++;
      if ($countones(~an) > 1) begin
        miscompares++;
        $display("FAIL one_anode cycle=%0d got an=%b expected at most one low", cycle_no, an);
      end
      if (an == 4'hF) begin
        dark_run++;
      end else begin
        if (an != prev_an) begin
          vectors++;
          if (prev_an != 4'hF || dark_run < 2) begin
            miscompares++;
            $display("FAIL dead_time cycle=%0d got prev_an=%b dark=%0d expected dark>=2 before an=%b",
                     cycle_no, prev_an, dark_run, an);
          end
        end
        dark_run = 0;
      end
      prev_an = an;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; lz_blank = 1'b0; digits_in = 16'h0000;

    // 1: reset values, then first frame of 1234 shown 4,3,2,1; two frames.
    cur_tag = 1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'h1234);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h1234);
    run(80, 1'b1, 1'b0, 1'b0, 16'h1234);

    // 2: single-cycle load mid-frame ignored; load held across boundary taken.
    cur_tag = 2;
    advance_to(14, 1'b0, 1'b0, 16'h1234);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'hABCD);
    advance_to(35, 1'b0, 1'b0, 16'hABCD);
    advance_to(2, 1'b1, 1'b0, 16'h5678);
    run(40, 1'b1, 1'b0, 1'b0, 16'h5678);

    // 3: leading-zero blanking; load rises exactly on the boundary cycle.
    cur_tag = 3;
    advance_to(39, 1'b0, 1'b1, 16'h0070);
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0070);
    run(39, 1'b1, 1'b0, 1'b1, 16'h0070);
    run(40, 1'b1, 1'b0, 1'b0, 16'h0070);
    advance_to(39, 1'b0, 1'b1, 16'h0000);
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
    run(39, 1'b1, 1'b0, 1'b1, 16'h0000);

    // 4: en drop mid digit-2 SHOW, resume at digit 0; en low beats a boundary.
    cur_tag = 4;
    advance_to(39, 1'b0, 1'b0, 16'h9E3F);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h9E3F);
    advance_to(26, 1'b0, 1'b0, 16'h9E3F);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h9E3F);
    run(3, 1'b0, 1'b0, 1'b0, 16'h9E3F);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h9E3F);
    run(39, 1'b1, 1'b0, 1'b0, 16'h9E3F);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h1111);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h1111);
    run(39, 1'b1, 1'b0, 1'b0, 16'h1111);

    // 5: reset mid-SHOW clears shadow; next run shows 0000.
    cur_tag = 5;
    advance_to(13, 1'b0, 1'b0, 16'h1111);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h1111);
    run(42, 1'b1, 1'b0, 1'b0, 16'h1111);

    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
